// File: rtl/orb_reader.sv
// orb_reader: read side of the orbital telemetry buffer RAM.
// Fetches words sequentially and serialises them MSB-first with sync markers.
module orb_reader #(
    parameter int ADDR_W  = 11,
    parameter int WORD_W  = 12,
    parameter int BIT_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WORD_W-1:0] rdData,
    output logic [ADDR_W-1:0] rdAddr,
    output logic              RE,
    output logic              sOut,
    output logic              bitStrobe,
    output logic              wordSync,
    output logic              frameSync,
    output logic              SW,
    output logic              busy
);

    localparam int DW = $clog2(BIT_DIV);
    localparam int BW = $clog2(WORD_W);
    localparam logic [DW-1:0] DIV_TOP = DW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_TOP = BW'(WORD_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic              en_meta;
    logic              en_s;
    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_n;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_n;
    logic [DW-1:0]     div_cnt;
    logic [DW-1:0]     div_cnt_n;
    logic [WORD_W-1:0] shift;
    logic [WORD_W-1:0] shift_n;
    logic [WORD_W-1:0] hold;
    logic              pf;
    logic              sw_n;
    logic              last;
    logic              in_shift_n;
    logic              sout_n;
    logic              strobe_n;
    logic              wsync_n;
    logic              fsync_n;

    assign last = &addr;
    assign busy = (state != S_IDLE);

    // One fetch in FETCH, then one prefetch of the next word per word period
    assign RE = (state == S_FETCH) ||
                ((state == S_SHIFT) && (bit_cnt == BIT_TOP) && (div_cnt == '0));
    assign rdAddr = (state == S_SHIFT) ? addr + ADDR_W'(1) : addr;

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        bit_cnt_n = bit_cnt;
        div_cnt_n = div_cnt;
        shift_n   = shift;
        sw_n      = SW;
        unique case (state)
            S_IDLE: begin
                if (en_s) state_n = S_FETCH;
            end
            S_FETCH: begin
                state_n = S_LOAD;
            end
            S_LOAD: begin
                shift_n   = rdData;
                bit_cnt_n = BIT_TOP;
                div_cnt_n = '0;
                state_n   = S_SHIFT;
            end
            S_SHIFT: begin
                if (div_cnt == DIV_TOP) begin
                    div_cnt_n = '0;
                    if (bit_cnt == '0) begin
                        if (en_s) begin
                            shift_n   = hold;
                            addr_n    = addr + ADDR_W'(1);
                            bit_cnt_n = BIT_TOP;
                            sw_n      = SW ^ last;
                        end else begin
                            state_n = S_DRAIN;
                        end
                    end else begin
                        shift_n   = {shift[WORD_W-2:0], 1'b0};
                        bit_cnt_n = bit_cnt - BW'(1);
                    end
                end else begin
                    div_cnt_n = div_cnt + DW'(1);
                end
            end
            S_DRAIN: begin
                addr_n  = addr + ADDR_W'(1);
                sw_n    = SW ^ last;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Serial outputs decoded from next-state values so they align with SHIFT
    always_comb begin
        in_shift_n = (state_n == S_SHIFT);
        sout_n     = in_shift_n && shift_n[WORD_W-1];
        strobe_n   = in_shift_n && (div_cnt_n == '0);
        wsync_n    = in_shift_n && (bit_cnt_n == BIT_TOP);
        fsync_n    = wsync_n && (addr_n == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_meta   <= 1'b0;
            en_s      <= 1'b0;
            state     <= S_IDLE;
            addr      <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            shift     <= '0;
            hold      <= '0;
            pf        <= 1'b0;
            SW        <= 1'b0;
            sOut      <= 1'b0;
            bitStrobe <= 1'b0;
            wordSync  <= 1'b0;
            frameSync <= 1'b0;
        end else begin
            en_meta   <= en;
            en_s      <= en_meta;
            state     <= state_n;
            addr      <= addr_n;
            bit_cnt   <= bit_cnt_n;
            div_cnt   <= div_cnt_n;
            shift     <= shift_n;
            pf        <= RE && (state == S_SHIFT);
            if (pf) hold <= rdData;
            SW        <= sw_n;
            sOut      <= sout_n;
            bitStrobe <= strobe_n;
            wordSync  <= wsync_n;
            frameSync <= fsync_n;
        end
    end

endmodule

// File: tb/tb_orb_reader.sv
// tb_orb_reader: directed bench for orb_reader with short frames.
// Two instances: BIT_DIV=4 for the main sequence and BIT_DIV=2 for the corner.
module tb_orb_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        en2 = 1'b0;
    logic [11:0] rd_data;
    logic [11:0] rd_data2;
    logic [3:0]  rd_addr;
    logic [3:0]  rd_addr2;
    logic        re, re2;
    logic        s_out, s_out2;
    logic        bit_strobe, bit_strobe2;
    logic        word_sync, word_sync2;
    logic        frame_sync, frame_sync2;
    logic        sw, sw2;
    logic        busy, busy2;

    logic        use2 = 1'b0;
    logic        m_bs, m_ws, m_fs, m_so, m_sw, m_re;
    logic [3:0]  m_addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int re_c[$];
    int re_a[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    orb_reader #(.ADDR_W(4), .WORD_W(12), .BIT_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .rdData(rd_data),
        .rdAddr(rd_addr), .RE(re), .sOut(s_out), .bitStrobe(bit_strobe),
        .wordSync(word_sync), .frameSync(frame_sync), .SW(sw), .busy(busy)
    );

    orb_reader #(.ADDR_W(4), .WORD_W(12), .BIT_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .rdData(rd_data2),
        .rdAddr(rd_addr2), .RE(re2), .sOut(s_out2), .bitStrobe(bit_strobe2),
        .wordSync(word_sync2), .frameSync(frame_sync2), .SW(sw2), .busy(busy2)
    );

    // Registered-read RAM models: mem[a] = 0x100 + a
    always @(posedge clk) if (re) rd_data <= 12'h100 + 12'(rd_addr);
    always @(posedge clk) if (re2) rd_data2 <= 12'h100 + 12'(rd_addr2);

    always_comb begin
        m_bs   = use2 ? bit_strobe2 : bit_strobe;
        m_ws   = use2 ? word_sync2 : word_sync;
        m_fs   = use2 ? frame_sync2 : frame_sync;
        m_so   = use2 ? s_out2 : s_out;
        m_sw   = use2 ? sw2 : sw;
        m_re   = use2 ? re2 : re;
        m_addr = use2 ? rd_addr2 : rd_addr;
    end

    always @(negedge clk) begin
        if (m_re) begin
            re_c.push_back(cyc);
            re_a.push_back(int'(m_addr));
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_re(input string tag, input int c, input int a);
        check({tag, "_seen"}, re_c.size() > 0, 1);
        if (re_c.size() > 0) begin
            check({tag, "_cyc"}, re_c.pop_front(), c);
            check({tag, "_addr"}, re_a.pop_front(), a);
        end
    endtask

    task automatic get_word(input int div, input int drop_c,
                            output logic [11:0] w, output int t0,
                            output int ws, output int fs,
                            output int sbad, output logic sw0);
        int n;
        n = 0; w = '0; t0 = -1; ws = 0; fs = 0; sbad = 0; sw0 = 1'b0;
        @(negedge clk);
        while (!(m_ws && m_bs) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("word_found", n < 300, 1);
        if (n >= 300) return;
        t0 = cyc;
        sw0 = m_sw;
        for (int c = 0; c < 12 * div; c++) begin
            if (c == drop_c) en = 1'b0;
            if (c % div == 0) begin
                w = {w[10:0], m_so};
                if (!m_bs) sbad++;
            end else if (m_bs) begin
                sbad++;
            end
            ws += int'(m_ws);
            fs += int'(m_fs);
            if (c < 12 * div - 1) @(negedge clk);
        end
    endtask

    task automatic do_word(input int i, input int a, input int drop_c,
                           input int prev_t0, input int fetch_c,
                           input logic exp_sw, output int t0);
        int div;
        logic [11:0] w;
        int ws, fs, sbad;
        logic sw0;
        div = use2 ? 2 : 4;
        get_word(div, drop_c, w, t0, ws, fs, sbad, sw0);
        check($sformatf("w%0d_val", i), w, 32'h100 + a);
        if (prev_t0 >= 0)
            check($sformatf("w%0d_gap", i), t0 - prev_t0, 12 * div);
        if (fetch_c >= 0) begin
            check($sformatf("w%0d_latency", i), t0 - fetch_c, 2);
            chk_re($sformatf("w%0d_fetch", i), fetch_c, a);
        end
        check($sformatf("w%0d_wsync", i), ws, div);
        check($sformatf("w%0d_fsync", i), fs, (a == 0) ? div : 0);
        check($sformatf("w%0d_strobe", i), sbad, 0);
        check($sformatf("w%0d_sw", i), sw0, exp_sw);
        chk_re($sformatf("w%0d_pf", i), t0, (a + 1) % 16);
    endtask

    initial begin
        int t_en, t0, prev, n;
        repeat (3) @(negedge clk);
        check("reset_outs", {rd_addr, re, s_out, bit_strobe, word_sync,
                             frame_sync, sw, busy}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        @(posedge clk);
        #1 en = 1'b1;
        t_en = cyc;
        do_word(0, 0, -1, -1, t_en + 3, 1'b0, t0);
        prev = t0;
        do_word(1, 1, -1, prev, -1, 1'b0, t0);
        prev = t0;
        do_word(2, 2, 21, prev, -1, 1'b0, t0);

        @(negedge clk);
        check("drain_sout", s_out, 0);
        check("drain_busy", busy, 1);
        @(negedge clk);
        check("idle_after_drain", busy, 0);
        repeat (5) @(negedge clk);
        check("idle_no_re", re_c.size(), 0);
        check("idle_sout", s_out, 0);

        @(posedge clk);
        #1 en = 1'b1;
        t_en = cyc;
        prev = -1;
        for (int i = 3; i < 57; i++) begin
            do_word(i, i % 16, -1, prev, (i == 3) ? t_en + 3 : -1,
                    1'((i / 16) % 2), t0);
            prev = t0;
        end

        // Word 57 (address 9) is cut by reset at its 8th bit period
        n = 0;
        @(negedge clk);
        while (!(word_sync && bit_strobe) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("w57_found", n < 300, 1);
        check("w57_gap", cyc - prev, 48);
        repeat (30) @(negedge clk);
        check("sw_before_rst", sw, 1);
        check("busy_before_rst", busy, 1);
        #2 rst = 1'b0;
        #1;
        check("rst_outs", {rd_addr, re, s_out, bit_strobe, word_sync,
                           frame_sync, sw, busy}, 0);
        re_c.delete();
        re_a.delete();
        @(negedge clk);
        en = 1'b1;
        rst = 1'b1;
        t_en = cyc;
        do_word(58, 0, -1, -1, t_en + 3, 1'b0, t0);
        prev = t0;
        do_word(59, 1, -1, prev, -1, 1'b0, t0);

        use2 = 1'b1;
        en = 1'b0;
        re_c.delete();
        re_a.delete();
        @(posedge clk);
        #1 en2 = 1'b1;
        t_en = cyc;
        prev = -1;
        for (int i = 0; i < 40; i++) begin
            do_word(100 + i, i % 16, -1, prev, (i == 0) ? t_en + 3 : -1,
                    1'((i / 16) % 2), t0);
            prev = t0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/orb_reader.md
Name: orb_reader

Overview:
- Read side of the orbital telemetry buffer RAM that the packer fills with 12-bit words.
- Fetches words sequentially from a registered-read RAM port (1-cycle latency) and serialises them MSB-first into a continuous bit stream at clk/BIT_DIV.
- Emits word and frame sync markers.
- Toggles the buffer-switch line SW at every frame boundary so the packer restarts its address counters.

Parameters:
- ADDR_W, 11, RAM address width; frame length = 2**ADDR_W words.
- WORD_W, 12, RAM word width and bits per serial word.
- BIT_DIV, 8, clk cycles per serial bit; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  stream enable, asynchronous; 2-FF synchronised internally.
- rdData  in  WORD_W  RAM read data; valid the cycle after RE.
- rdAddr  out  ADDR_W  RAM read address.
- RE  out  1  RAM read enable, one-cycle pulse per fetch.
- sOut  out  1  serial data, MSB first.
- bitStrobe  out  1  one-cycle pulse on the first clk of every bit period.
- wordSync  out  1  high for the whole bit period of bit WORD_W-1 (first bit) of each word.
- frameSync  out  1  high for the first bit period of word address 0.
- SW  out  1  buffer-switch level; toggles once per completed frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: rdAddr=0, RE=0, sOut=0, bitStrobe=0, wordSync=0, frameSync=0, SW=0, busy=0. Internal registers: state=IDLE, addr=0, bitCnt=0, divCnt=0, shift=0, hold=0.
- "enS" below means the 2-FF-synchronised en.
- States: IDLE, FETCH, LOAD, SHIFT, DRAIN.
- IDLE:
  - sOut=0.
  - When enS=1: go to FETCH, with addr kept at its current value (0 after reset).
- FETCH (1 cycle): RE=1, rdAddr=addr; go to LOAD.
- LOAD (1 cycle): shift<=rdData; bitCnt<=WORD_W-1; divCnt<=0; go to SHIFT.
- First-bit latency: first bit starts 3 clk after the cycle in which enS is first seen high.
- SHIFT:
  - sOut=shift[WORD_W-1].
  - divCnt counts 0..BIT_DIV-1; bitStrobe=1 when divCnt==0.
  - On divCnt==BIT_DIV-1: shift<<=1, bitCnt-=1.
- Prefetch:
  - In the cycle with bitCnt==WORD_W-1 and divCnt==0, issue RE=1 with rdAddr=addr+1 (wrapping modulo 2**ADDR_W).
  - Capture rdData into hold on the next cycle.
  - Exactly one RE per word.
- Word end (bitCnt==0 and divCnt==BIT_DIV-1):
  - If enS=1: shift<=hold, addr<=addr+1 (wrapping), bitCnt<=WORD_W-1. The next word starts with no idle cycle; word period is exactly WORD_W*BIT_DIV clk.
  - If enS=0: go to DRAIN.
- Frame wrap:
  - When the word at address 2**ADDR_W-1 completes and the next word (address 0) is loaded, SW toggles in that same cycle.
  - frameSync is high for that word's first bit period.
- DRAIN (1 cycle):
  - sOut=0.
  - addr<=addr+1, i.e. resume at the next unsent word; the prefetched word is discarded.
  - If that completed word was address 2**ADDR_W-1, SW toggles here as well.
  - Go to IDLE.
- en deassertion mid-word never truncates the word: the current word always finishes all WORD_W bits.
- wordSync and frameSync are combinational decodes of state/bitCnt/addr, registered together with sOut so all three align.
- Asynchronous reset mid-stream: everything returns to reset values immediately and SW returns to 0. After release, streaming restarts at address 0.
- en re-asserted in the DRAIN cycle: ignored until IDLE, then normal FETCH.

Test Plan (BIT_DIV=4, ADDR_W=4 for short frames, RAM model mem[a]=12'h100+a):
- Reset then en=1 -> RE pulses with rdAddr=0 three cycles after en sync; sOut then carries 0001_0000_0000 MSB-first, 4 clk per bit; wordSync and frameSync high for the first 4 clk; bitStrobe every 4 clk.
- Continuous streaming of 3 words -> words 0x100, 0x101, 0x102 back-to-back, 48 clk each with no gap; exactly one RE per word, issued at each word's first bitStrobe with rdAddr=word+1.
- Run 16+1 words -> after word address 15 completes, SW goes 0->1 in the same cycle word 0 starts; frameSync high again; after 32 words SW returns to 0.
- Drop en at bit 5 of word 2 -> word 2 completes all 12 bits, then sOut=0, busy=0. Re-raise en -> stream resumes at address 3 with a 3-clk start latency.
- Assert rst low at bit 7 of word 9 -> all outputs 0 immediately, including SW=0. Release with en=1 -> first word fetched is address 0.
- BIT_DIV=2 corner: gapless back-to-back words; hold captured before the word boundary; no repeated or skipped addresses over 40 words.
